alarm_sequencer: RTL and testbench

Controller that sequences the alarm register and buzzer of the digital clock. It compares running time against the stored alarm time and runs the ring / snooze / stop state machine. It issues one-cycle snooze and restore commands to the alarm register and locks alarm editing while an alarm is in progress. It sits between the timekeeping counter, the debounced push-buttons, the alarm register and the buzzer driver.

---
 rtl/clock_pkg.sv | 15 +
 rtl/ring_timer.sv | 39 +++
 rtl/alarm_sequencer.sv | 112 +++++++++++
 tb/tb_alarm_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared alarm state type and time constants for the digital clock
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } alm_state_t;

  localparam int SNOOZE_MIN = 5;
  localparam int HR_MAX     = 23;
  localparam int MIN_MAX    = 59;

endpackage

// File: rtl/ring_timer.sv
// rtl/ring_timer.sv - per-second ring duration counter and buzzer toggle
module ring_timer #(
  parameter int RING_SECS = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clear,
  input  logic enable,
  input  logic stop,
  output logic done,
  output logic buzz
);
  import clock_pkg::*;

  localparam logic [7:0] LAST = 8'(RING_SECS - 1);

  logic [7:0] count;

  // clear starts a ring with the buzzer on; stop silences it outside RINGING
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
      buzz  <= 1'b0;
    end else if (clear) begin
      count <= 8'd0;
      buzz  <= 1'b1;
    end else if (stop) begin
      count <= 8'd0;
      buzz  <= 1'b0;
    end else if (enable && tick) begin
      if (count != 8'hFF) count <= count + 8'd1;
      buzz <= ~buzz;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm match, ring/snooze/stop FSM and alarm register commands
module alarm_sequencer #(
  parameter int RING_SECS  = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [5:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] alm_hr,
  input  logic [5:0] alm_min,
  input  logic       arm,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snooze_pulse,
  output logic       restore_pulse,
  output logic       cfg_lock,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt
);
  import clock_pkg::*;

  localparam logic [2:0] SNOOZE_LIMIT = 3'(MAX_SNOOZE);

  alm_state_t cur_state;
  alm_state_t nxt_state;
  logic       match;
  logic       ring_done;
  logic       timeout;
  logic       do_snooze;
  logic       do_restore;
  logic [2:0] nxt_cnt;

  assign match   = tick_1hz && (cur_sec == 6'd0) && (cur_hr == alm_hr) && (cur_min == alm_min);
  assign timeout = tick_1hz && ring_done;

  // priority: arm=0 > stop > timeout > snooze > match
  always_comb begin
    nxt_state  = cur_state;
    nxt_cnt    = snooze_cnt;
    do_snooze  = 1'b0;
    do_restore = 1'b0;
    if (!arm) begin
      nxt_state  = IDLE;
      nxt_cnt    = 3'd0;
      do_restore = (snooze_cnt != 3'd0);
    end else begin
      unique case (cur_state)
        IDLE:  nxt_state = ARMED;
        ARMED: if (match) nxt_state = RINGING;
        RINGING: begin
          if (stop_btn || timeout) begin
            nxt_state  = ARMED;
            nxt_cnt    = 3'd0;
            do_restore = (snooze_cnt != 3'd0);
          end else if (snooze_btn && (snooze_cnt < SNOOZE_LIMIT)) begin
            nxt_state = SNOOZED;
            nxt_cnt   = snooze_cnt + 3'd1;
            do_snooze = 1'b1;
          end
        end
        SNOOZED: begin
          if (stop_btn) begin
            nxt_state  = ARMED;
            nxt_cnt    = 3'd0;
            do_restore = (snooze_cnt != 3'd0);
          end else if (match) begin
            nxt_state = RINGING;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state     <= IDLE;
      snooze_cnt    <= 3'd0;
      snooze_pulse  <= 1'b0;
      restore_pulse <= 1'b0;
      ringing       <= 1'b0;
      cfg_lock      <= 1'b0;
    end else begin
      cur_state     <= nxt_state;
      snooze_cnt    <= nxt_cnt;
      snooze_pulse  <= do_snooze;
      restore_pulse <= do_restore;
      ringing       <= (nxt_state == RINGING);
      cfg_lock      <= (nxt_state == RINGING) || (nxt_state == SNOOZED);
    end
  end

  assign state = cur_state;

  ring_timer #(
    .RING_SECS(RING_SECS)
  ) u_ring_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick_1hz),
    .clear  ((nxt_state == RINGING) && (cur_state != RINGING)),
    .enable (cur_state == RINGING),
    .stop   (nxt_state != RINGING),
    .done   (ring_done),
    .buzz   (buzzer)
  );

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - vector table, corner sequences and randomized model check for alarm_sequencer
module tb_alarm_sequencer;
  import clock_pkg::*;

  localparam int RING_SECS  = 60;
  localparam int MAX_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       rst_n, arm, tick_1hz, snooze_btn, stop_btn;
  logic [5:0] cur_hr, cur_min, cur_sec, alm_hr, alm_min;
  logic       buzzer, ringing, snooze_pulse, restore_pulse, cfg_lock;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int ah = 7;
  int am = 30;

  always #5 clk = ~clk;

  alarm_sequencer #(
    .RING_SECS (RING_SECS),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .cur_hr       (cur_hr),
    .cur_min      (cur_min),
    .cur_sec      (cur_sec),
    .alm_hr       (alm_hr),
    .alm_min      (alm_min),
    .arm          (arm),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snooze_pulse (snooze_pulse),
    .restore_pulse(restore_pulse),
    .cfg_lock     (cfg_lock),
    .state        (state),
    .snooze_cnt   (snooze_cnt)
  );

  typedef struct {
    int rn, a, t, sz, sp, h, m, s, ah, am;
    int st, bz, snp, rp, cnt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mkv(input int rn, a, t, sz, sp, h, m, s, vah, vam, st, bz, snp, rp, cnt);
    vec_t v;
    v.rn = rn; v.a = a; v.t = t; v.sz = sz; v.sp = sp;
    v.h = h; v.m = m; v.s = s; v.ah = vah; v.am = vam;
    v.st = st; v.bz = bz; v.snp = snp; v.rp = rp; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input int rn, a, t, sz, sp, h, m, s);
    rst_n      = 1'(rn);
    arm        = 1'(a);
    tick_1hz   = 1'(t);
    snooze_btn = 1'(sz);
    stop_btn   = 1'(sp);
    cur_hr     = 6'(h);
    cur_min    = 6'(m);
    cur_sec    = 6'(s);
    alm_hr     = 6'(ah);
    alm_min    = 6'(am);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int st, bz, snp, rp, cnt);
    logic [9:0] got, exp;
    got = {state, buzzer, ringing, snooze_pulse, restore_pulse, cfg_lock, snooze_cnt};
    exp = {2'(st), 1'(bz), 1'(st == 2), 1'(snp), 1'(rp), 1'(st >= 2), 3'(cnt)};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b [state,buzzer,ringing,snooze_pulse,restore_pulse,cfg_lock,snooze_cnt]",
               name, got, exp);
    end
  endtask

  initial begin
    // rn a t sz sp  hh mm ss  ah am | st bz snp rp cnt
    tbl[0]  = mkv(0,0,0,0,0, 7,29,59, 7,30, 0,0,0,0,0);
    tbl[1]  = mkv(1,1,0,0,0, 7,29,59, 7,30, 1,0,0,0,0);
    tbl[2]  = mkv(1,1,1,0,0, 7,29,59, 7,30, 1,0,0,0,0);
    tbl[3]  = mkv(1,1,1,0,0, 7,30, 0, 7,30, 2,1,0,0,0);
    tbl[4]  = mkv(1,1,0,0,0, 7,30, 0, 7,30, 2,1,0,0,0);
    tbl[5]  = mkv(1,1,1,0,0, 7,30, 1, 7,30, 2,0,0,0,0);
    tbl[6]  = mkv(1,1,1,0,0, 7,30, 2, 7,30, 2,1,0,0,0);
    tbl[7]  = mkv(1,1,0,1,0, 7,30, 2, 7,30, 3,0,1,0,1);
    tbl[8]  = mkv(1,1,0,0,0, 7,30, 3, 7,35, 3,0,0,0,1);
    tbl[9]  = mkv(1,1,1,0,0, 7,35, 0, 7,35, 2,1,0,0,1);
    tbl[10] = mkv(1,1,0,0,1, 7,35, 1, 7,35, 1,0,0,1,0);
    tbl[11] = mkv(1,1,0,0,0, 7,35, 1, 7,30, 1,0,0,0,0);
    tbl[12] = mkv(1,0,0,0,0, 7,35, 1, 7,30, 0,0,0,0,0);
    tbl[13] = mkv(1,0,1,1,1, 7,30, 0, 7,30, 0,0,0,0,0);
    tbl[14] = mkv(1,1,0,0,0, 7,30, 0, 7,30, 1,0,0,0,0);
    tbl[15] = mkv(1,1,0,1,1, 7,30, 5, 7,30, 1,0,0,0,0);
    tbl[16] = mkv(1,1,1,0,0, 7,30, 5, 7,30, 1,0,0,0,0);
    tbl[17] = mkv(1,1,1,0,0, 7,31, 0, 7,30, 1,0,0,0,0);

    for (int i = 0; i < 18; i++) begin
      ah = tbl[i].ah;
      am = tbl[i].am;
      drive(tbl[i].rn, tbl[i].a, tbl[i].t, tbl[i].sz, tbl[i].sp, tbl[i].h, tbl[i].m, tbl[i].s);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].bz, tbl[i].snp, tbl[i].rp, tbl[i].cnt);
    end

    // three snoozes, a refused fourth, then stop with restore
    ah = 7; am = 30;
    for (int i = 0; i < 3; i++) begin
      drive(1,1,1,0,0, 7, 30 + 5*i, 0); chk("snz_ring", 2,1,0,0,i);
      drive(1,1,0,1,0, 7, 30 + 5*i, 1); chk("snz_take", 3,0,1,0,i+1);
      am = 35 + 5*i;
    end
    drive(1,1,1,0,0, 7,45,0); chk("snz_ring4", 2,1,0,0,3);
    drive(1,1,0,1,0, 7,45,1); chk("snz_4th",   2,1,0,0,3);
    drive(1,1,0,0,1, 7,45,2); chk("snz_stop",  1,0,0,1,0);
    am = 30;
    drive(1,1,0,0,0, 7,45,2); chk("rst_once",  1,0,0,0,0);

    // auto-stop on the RING_SECS-th tick
    drive(1,1,1,0,0, 7,30,0); chk("to_ring", 2,1,0,0,0);
    for (int k = 1; k <= RING_SECS; k++) begin
      drive(1,1,1,0,0, 7,31, k % 60);
      if (k < RING_SECS) chk("to_tick", 2, (k % 2 == 0) ? 1 : 0, 0,0,0);
      else               chk("to_done", 1,0,0,0,0);
    end

    // stop beats snooze in the same cycle
    drive(1,1,1,0,0, 7,30,0); chk("both_ring", 2,1,0,0,0);
    drive(1,1,0,1,1, 7,30,1); chk("both_btn",  1,0,0,0,0);

    // disarm while snoozed twice
    drive(1,1,1,0,0, 7,30,0); chk("dis_ring1", 2,1,0,0,0);
    drive(1,1,0,1,0, 7,30,1); chk("dis_snz1",  3,0,1,0,1);
    am = 35;
    drive(1,1,1,0,0, 7,35,0); chk("dis_ring2", 2,1,0,0,1);
    drive(1,1,0,1,0, 7,35,1); chk("dis_snz2",  3,0,1,0,2);
    am = 40;
    drive(1,0,0,0,0, 7,35,2); chk("dis_idle",  0,0,0,1,0);
    am = 30;
    drive(1,0,0,0,0, 7,35,3); chk("dis_once",  0,0,0,0,0);

    // reset while ringing
    drive(1,1,0,0,0, 7,30,0); chk("rr_arm",  1,0,0,0,0);
    drive(1,1,1,0,0, 7,30,0); chk("rr_ring", 2,1,0,0,0);
    drive(0,1,1,0,0, 7,30,1); chk("rr_rst",  0,0,0,0,0);
    drive(1,1,0,0,0, 7,30,2); chk("rr_rearm",1,0,0,0,0);

    // randomized run against a rule-level model with an alarm register model
    begin
      int ms, mc, mt, mb, msnp, mrp;
      int prog_hr, prog_min;
      prog_hr  = $urandom_range(0, HR_MAX);
      prog_min = $urandom_range(0, MIN_MAX);
      ah = prog_hr; am = prog_min;
      ms = 0; mc = 0; mt = 0; mb = 0;
      drive(0,1,0,0,0, 0,0,0); chk("rand_rst", 0,0,0,0,0);
      for (int n = 0; n < 4000; n++) begin
        int rn, a, t, sz, sp, h, m, s, hit, tot;
        rn = ($urandom_range(0, 99) != 0) ? 1 : 0;
        a  = ($urandom_range(0, 49) != 0) ? 1 : 0;
        t  = $urandom_range(0, 1);
        sz = ($urandom_range(0, 5) == 0) ? 1 : 0;
        sp = ($urandom_range(0, 15) == 0) ? 1 : 0;
        if ($urandom_range(0, 2) == 0) begin
          h = ah; m = am; s = 0;
        end else begin
          h = $urandom_range(0, HR_MAX);
          m = $urandom_range(0, MIN_MAX);
          s = $urandom_range(0, 59);
        end
        hit  = (t == 1 && s == 0 && h == ah && m == am) ? 1 : 0;
        msnp = 0;
        mrp  = 0;
        if (rn == 0) begin
          ms = 0; mc = 0; mt = 0; mb = 0;
        end else if (a == 0) begin
          mrp = (mc != 0) ? 1 : 0; ms = 0; mc = 0; mb = 0;
        end else if (ms == 0) begin
          ms = 1;
        end else if (ms == 1) begin
          if (hit == 1) begin ms = 2; mt = 0; mb = 1; end
        end else if (ms == 2 && (sp == 1 || (t == 1 && mt == RING_SECS - 1))) begin
          mrp = (mc != 0) ? 1 : 0; ms = 1; mc = 0; mb = 0;
        end else if (ms == 2 && sz == 1 && mc < MAX_SNOOZE) begin
          msnp = 1; ms = 3; mc = mc + 1; mb = 0;
        end else if (ms == 2) begin
          if (t == 1) begin mt = mt + 1; mb = 1 - mb; end
        end else if (sp == 1) begin
          mrp = (mc != 0) ? 1 : 0; ms = 1; mc = 0;
        end else if (hit == 1) begin
          ms = 2; mt = 0; mb = 1;
        end
        drive(rn, a, t, sz, sp, h, m, s);
        chk("random", ms, mb, msnp, mrp, mc);
        if (rn == 0 || mrp == 1) begin
          ah = prog_hr; am = prog_min;
        end else if (msnp == 1) begin
          tot = (ah * (MIN_MAX + 1) + am + SNOOZE_MIN) % ((HR_MAX + 1) * (MIN_MAX + 1));
          ah  = tot / (MIN_MAX + 1);
          am  = tot % (MIN_MAX + 1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
